// File: rtl/channel_sched_bdeduffy_pkg.sv
// Shared word layout, FSM encoding and framing helper for the channel scheduler.
// Pure definitions: no latency, no flow control.
package channel_sched_bdeduffy_pkg;

  localparam int WORD_W  = 10;
  localparam int ID_MSB  = 9;
  localparam int ID_LSB  = 8;
  localparam int PAY_MSB = 7;
  localparam int PAY_LSB = 1;
  localparam int PAR_BIT = 0;
  localparam int ID_W    = ID_MSB - ID_LSB + 1;
  localparam int PAY_W   = PAY_MSB - PAY_LSB + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_t;

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [PAY_W-1:0] payload;
    logic             parity;
  } word_t;

  // Even parity: the parity bit makes the XOR of the whole word zero.
  function automatic word_t frame_word(input logic [ID_W-1:0] id, input logic [PAY_W-1:0] payload);
    word_t w;
    w.id      = id;
    w.payload = payload;
    w.parity  = ^{id, payload};
    return w;
  endfunction

endpackage

// File: rtl/channel_sched_bdeduffy_if.sv
// Requester and channel signals of the scheduler; master = scheduler side.
// Level requests held until ack/nak; tx/rx are single-cycle strobes.
interface channel_sched_bdeduffy_if #(
  parameter int N_REQ     = 4,
  parameter int PAYLOAD_W = 7
);
  import channel_sched_bdeduffy_pkg::*;

  logic [N_REQ-1:0]           req;
  logic [N_REQ*PAYLOAD_W-1:0] payload;
  logic [N_REQ-1:0]           ack;
  logic [N_REQ-1:0]           nak;
  logic                       tx_en;
  logic [WORD_W-1:0]          tx_word;
  logic                       rx_valid;
  logic [WORD_W-1:0]          rx_word;
  logic                       busy;
  logic [ID_W-1:0]            grant_id;

  modport master (
    input  req, payload, rx_valid, rx_word,
    output ack, nak, tx_en, tx_word, busy, grant_id
  );

  modport slave (
    output req, payload, rx_valid, rx_word,
    input  ack, nak, tx_en, tx_word, busy, grant_id
  );

endinterface

// File: rtl/channel_sched_bdeduffy_arb.sv
// Combinational round-robin pick: first set request at or after ptr.
// Zero latency; valid low when nothing is requesting.
module rr_arbiter_bdeduffy
  import channel_sched_bdeduffy_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [ID_W-1:0] grant,
  output logic            valid
);

  logic [ID_W-1:0] idx;

  // Scan from the farthest offset down so the nearest one to ptr wins last.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = ptr + k[ID_W-1:0];
      if (req[idx]) begin
        grant = idx;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/channel_sched_bdeduffy.sv
// Round-robin channel scheduler: frames, launches, checks echo, retries, reports ack/nak.
// Launch 1 cycle after grant, ack 2 edges after launch; new requests wait while busy.
module channel_sched_bdeduffy
  import channel_sched_bdeduffy_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int PAYLOAD_W = 7,
  parameter int TIMEOUT   = 8,
  parameter int MAX_RETRY = 3
) (
  input  logic clk,
  input  logic clr_n,
  channel_sched_bdeduffy_if.master bus
);

  state_t             state, state_nxt;
  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    id_q;
  logic [2:0]         retry_q;
  logic [7:0]         timer_q;
  logic [WORD_W-1:0]  tx_word_q;
  logic [N_REQ-1:0]   ack_q, nak_q;

  logic [ID_W-1:0]      arb_grant;
  logic                 arb_valid;
  logic [PAYLOAD_W-1:0] pay_sel;
  logic [N_REQ-1:0]     id_onehot;
  logic                 load, retry_inc, done_ok, done_fail, fail;

  rr_arbiter_bdeduffy #(.N(N_REQ)) u_arb (
    .req   (bus.req),
    .ptr   (ptr),
    .grant (arb_grant),
    .valid (arb_valid)
  );

  assign pay_sel   = bus.payload[arb_grant*PAYLOAD_W +: PAYLOAD_W];
  assign id_onehot = N_REQ'(1) << id_q;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    load         = 1'b0;
    retry_inc    = 1'b0;
    done_ok      = 1'b0;
    done_fail    = 1'b0;
    fail         = 1'b0;
    bus.tx_en    = 1'b0;
    bus.busy     = 1'b1;
    case (state)
      IDLE: begin
        bus.busy = 1'b0;
        if (arb_valid) begin
          load      = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        bus.tx_en = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        // A returning word outranks the timeout in the same cycle.
        if (bus.rx_valid) begin
          if (bus.rx_word == tx_word_q) begin
            done_ok   = 1'b1;
            state_nxt = IDLE;
          end else begin
            fail = 1'b1;
          end
        end else if (timer_q == 8'(TIMEOUT - 1)) begin
          fail = 1'b1;
        end
        if (fail) begin
          if (retry_q < 3'(MAX_RETRY)) begin
            retry_inc = 1'b1;
            state_nxt = SEND;
          end else begin
            done_fail = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      ptr       <= '0;
      id_q      <= '0;
      retry_q   <= '0;
      timer_q   <= '0;
      tx_word_q <= '0;
      ack_q     <= '0;
      nak_q     <= '0;
    end else begin
      ack_q <= done_ok   ? id_onehot : '0;
      nak_q <= done_fail ? id_onehot : '0;
      if (load) begin
        id_q      <= arb_grant;
        retry_q   <= '0;
        tx_word_q <= frame_word(arb_grant, pay_sel);
      end else if (retry_inc) begin
        retry_q <= retry_q + 3'd1;
      end
      timer_q <= (state == WAIT) ? timer_q + 8'd1 : 8'd0;
      if (done_ok || done_fail) ptr <= id_q + ID_W'(1);
    end
  end

  assign bus.ack      = ack_q;
  assign bus.nak      = nak_q;
  assign bus.tx_word  = tx_word_q;
  assign bus.grant_id = id_q;

endmodule

// File: tb/tb_channel_sched_bdeduffy.sv
// Scoreboard bench for channel_sched_bdeduffy: directed requests with hand-framed words.
// Stimulus queues expected tx/ack/nak events; a negedge monitor pops and compares.
module tb_channel_sched_bdeduffy;

  logic clk = 1'b0;
  logic clr_n = 1'b1;
  always #5 clk = ~clk;

  channel_sched_bdeduffy_if #(.N_REQ(4), .PAYLOAD_W(7)) bus ();

  channel_sched_bdeduffy #(
    .N_REQ(4), .PAYLOAD_W(7), .TIMEOUT(8), .MAX_RETRY(3)
  ) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  typedef enum int {EV_TX = 0, EV_ACK = 1, EV_NAK = 2} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    int         id;
    logic [9:0] word;
  } ev_t;

  localparam int LB_NONE  = 0;
  localparam int LB_IDEAL = 1;
  localparam int LB_LATE  = 2;

  ev_t  sb[$];
  int   tx_times[$];
  int   done_times[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   pend[4];
  int   lb_mode = LB_IDEAL;
  int   corrupt_left = 0;
  int   req_cyc = 0;
  logic [9:0] lb_w;

  always @(posedge clk) cyc++;

  always_comb for (int i = 0; i < 4; i++) bus.req[i] = (pend[i] > 0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input ev_kind_t k, input int id, input logic [9:0] w);
    ev_t e;
    e.kind = k;
    e.id   = id;
    e.word = w;
    sb.push_back(e);
  endtask

  task automatic expect_pop(input ev_kind_t k, input int id, input logic [9:0] w);
    ev_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d id %0d word %0h, none pending", k, id, w);
    end else begin
      e = sb.pop_front();
      check("event_kind", k, e.kind);
      check("event_id", id, e.id);
      if (e.kind == EV_TX) check("tx_word", w, e.word);
    end
  endtask

  // Monitor: every DUT output event is matched against the scoreboard.
  always @(negedge clk) begin
    if (clr_n) begin
      if (bus.tx_en) begin
        tx_times.push_back(cyc);
        expect_pop(EV_TX, int'(bus.grant_id), bus.tx_word);
      end
      if (bus.ack != 4'b0 || bus.nak != 4'b0) begin
        int id;
        id = 0;
        for (int i = 0; i < 4; i++) if (bus.ack[i] || bus.nak[i]) id = i;
        check("ack_nak_onehot", $onehot(bus.ack | bus.nak), 1);
        check("busy_at_done", bus.busy, 0);
        done_times.push_back(cyc);
        if (pend[id] > 0) pend[id]--;
        expect_pop(bus.ack != 4'b0 ? EV_ACK : EV_NAK, id, 10'h0);
      end
    end
  end

  // Loopback model of the transmitter/receiver pair.
  always begin
    @(negedge clk);
    if (clr_n && bus.tx_en && lb_mode != LB_NONE) begin
      lb_w = bus.tx_word;
      if (corrupt_left > 0) begin
        lb_w[0] = ~lb_w[0];
        corrupt_left--;
      end
      @(posedge clk);
      if (lb_mode == LB_LATE) repeat (7) @(posedge clk);
      #1;
      bus.rx_valid = 1'b1;
      bus.rx_word  = lb_w;
      @(posedge clk);
      #1;
      bus.rx_valid = 1'b0;
    end
  end

  task automatic wait_idle(input string name, input int limit);
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.busy || bus.req != 4'b0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= limit) begin
      errors++;
      $display("FAIL %s_timeout: still busy after %0d cycles, %0d events pending", name, n, sb.size());
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"}, bus.ack, 0);
    check({tag, "_nak"}, bus.nak, 0);
    check({tag, "_tx_en"}, bus.tx_en, 0);
    check({tag, "_tx_word"}, bus.tx_word, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_grant_id"}, bus.grant_id, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) pend[i] = 0;
    bus.payload  = '0;
    bus.rx_valid = 1'b0;
    bus.rx_word  = '0;
    #1 clr_n = 1'b0;
    #2 check_reset_outputs("reset");
    @(negedge clk) clr_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single request, latency from req to launch and launch to ack.
    bus.payload[6:0] = 7'h55;
    push(EV_TX, 0, 10'h0AA);
    push(EV_ACK, 0, 10'h0);
    tx_times.delete();
    done_times.delete();
    req_cyc = cyc;
    pend[0] = 1;
    wait_idle("single", 50);
    check("single_tx_count", tx_times.size(), 1);
    if (tx_times.size() > 0) check("single_launch_latency", tx_times[0] - req_cyc, 1);
    if (tx_times.size() > 0 && done_times.size() > 0)
      check("single_ack_latency", done_times[0] - tx_times[0], 2);

    // Stray receive word while idle must be ignored.
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_word  = 10'h0AA;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_rx_busy", bus.busy, 0);

    // Fairness from a fresh pointer: 0,1,2,3,0.
    @(negedge clk) clr_n = 1'b0;
    @(negedge clk) clr_n = 1'b1;
    @(negedge clk);
    bus.payload = {7'h7F, 7'h03, 7'h02, 7'h01};
    push(EV_TX, 0, 10'h003); push(EV_ACK, 0, 10'h0);
    push(EV_TX, 1, 10'h104); push(EV_ACK, 1, 10'h0);
    push(EV_TX, 2, 10'h207); push(EV_ACK, 2, 10'h0);
    push(EV_TX, 3, 10'h3FF); push(EV_ACK, 3, 10'h0);
    push(EV_TX, 0, 10'h003); push(EV_ACK, 0, 10'h0);
    pend[0] = 2; pend[1] = 1; pend[2] = 1; pend[3] = 1;
    wait_idle("fair", 200);

    // Corrupted first echo forces one retry of the identical word.
    bus.payload[13:7] = 7'h2A;
    corrupt_left = 1;
    push(EV_TX, 1, 10'h154);
    push(EV_TX, 1, 10'h154);
    push(EV_ACK, 1, 10'h0);
    pend[1] = 1;
    wait_idle("retry", 100);

    // No echo at all: four launches nine cycles apart, then nak.
    lb_mode = LB_NONE;
    bus.payload[20:14] = 7'h11;
    for (int i = 0; i < 4; i++) push(EV_TX, 2, 10'h223);
    push(EV_NAK, 2, 10'h0);
    tx_times.delete();
    done_times.delete();
    req_cyc = cyc;
    pend[2] = 1;
    wait_idle("exhaust", 100);
    check("exhaust_tx_count", tx_times.size(), 4);
    for (int i = 1; i < tx_times.size(); i++)
      check("exhaust_tx_spacing", tx_times[i] - tx_times[i-1], 9);
    if (done_times.size() > 0) check("exhaust_worst_case", done_times[0] - req_cyc, 37);

    // Pointer moved past 2, so requester 3 beats requester 0.
    lb_mode = LB_IDEAL;
    bus.payload[27:21] = 7'h7F;
    bus.payload[6:0]   = 7'h55;
    push(EV_TX, 3, 10'h3FF); push(EV_ACK, 3, 10'h0);
    push(EV_TX, 0, 10'h0AA); push(EV_ACK, 0, 10'h0);
    pend[0] = 1; pend[3] = 1;
    wait_idle("ptr_adv", 100);

    // Matching echo lands on the last timer cycle: ack, no retry.
    lb_mode = LB_LATE;
    bus.payload[27:21] = 7'h40;
    push(EV_TX, 3, 10'h381);
    push(EV_ACK, 3, 10'h0);
    tx_times.delete();
    done_times.delete();
    pend[3] = 1;
    wait_idle("simul", 60);
    if (tx_times.size() > 0 && done_times.size() > 0)
      check("simul_ack_latency", done_times[0] - tx_times[0], 9);

    // Asynchronous reset in the middle of WAIT.
    lb_mode = LB_NONE;
    bus.payload[6:0] = 7'h55;
    push(EV_TX, 0, 10'h0AA);
    tx_times.delete();
    pend[0] = 1;
    for (int n = 0; n < 10 && tx_times.size() == 0; n++) @(negedge clk);
    check("midwait_launched", tx_times.size(), 1);
    repeat (3) @(negedge clk);
    #2 clr_n = 1'b0;
    #1 check_reset_outputs("midwait");
    check("midwait_pending", sb.size(), 0);
    repeat (2) @(negedge clk);
    lb_mode = LB_IDEAL;
    push(EV_TX, 0, 10'h0AA);
    push(EV_ACK, 0, 10'h0);
    clr_n = 1'b1;
    wait_idle("after_reset", 50);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
